// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide unit controller for the E-stage HI/LO datapath.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO (and MADD when MDU_MADD_EN is
// defined) and sequences a fixed-latency busy window. It owns the
// architectural HI/LO registers and raises a stall request for the hazard
// unit while a dependent MDU/MFHI/MFLO instruction sits in D.
//
// Optional feature macro: MDU_MADD_EN
//   defined   : Op 7 = MADD, {HI,LO} += signed(A*B), MUL_CYCLES latency
//   undefined : Op 7 is a NOP and no accumulator adder exists
//
// Ports:
//   Clk, Reset  clock; synchronous active-high reset
//   Start, Op   E-stage MDU request and opcode
//   A, B        forwarded rs / rt operands
//   MDUse       D-stage instruction uses the MDU or reads HI/LO
//   HI, LO      architectural HI/LO (read combinationally by write-back)
//   Busy        operation in flight
//   Stall       stall request to the hazard unit
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDUse,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Stall
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MADD  = 3'd7
  } op_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, b_q;
  op_e         op_q;
  op_e         op_in;
  logic        load_ops;
  logic        start_long;

  assign op_in = op_e'(Op);

  // Ops that open a busy window; only these can raise Stall from Start.
  always_comb begin
    start_long = 1'b0;
    case (op_in)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_long = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD: start_long = 1'b1;
`endif
      default: start_long = 1'b0;
    endcase
  end

  // ---------------- Datapath on the latched operands ----------------
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed division is done on magnitudes with a single unsigned divider,
  // then re-signed: quotient truncates toward zero, remainder follows the
  // dividend. 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
  logic        div_signed, a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur, quo, rem;
  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign ua         = a_neg ? -a_q : a_q;
  assign ub         = b_neg ? -b_q : b_q;
  // Divide-by-zero never commits; the guard only keeps the divider defined.
  assign ub_safe    = (ub == '0) ? 32'd1 : ub;
  assign uq         = ua / ub_safe;
  assign ur         = ua % ub_safe;
  assign quo        = (a_neg ^ b_neg) ? -uq : uq;
  assign rem        = a_neg ? -ur : ur;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q} + prod_s;
`endif

  // ---------------- Next-state / register update ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    load_ops = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              state_d  = S_BUSY;
              cnt_d    = 4'(MUL_CYCLES);
              load_ops = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d  = S_BUSY;
              cnt_d    = 4'(DIV_CYCLES);
              load_ops = 1'b1;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              state_d  = S_BUSY;
              cnt_d    = 4'(MUL_CYCLES);
              load_ops = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
              if (b_q != '0) begin
                lo_d = quo;
                hi_d = rem;
              end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = acc;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (load_ops) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op_in;
      end
    end
  end

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Busy  = (state_q == S_BUSY);
  assign Stall = MDUse & (Busy | (Start & start_long));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- directed self-checking bench for mdu_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mdu_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        MDUse;
  logic [31:0] HI, LO;
  logic        Busy, Stall;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mdu_ctrl #(
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .MDUse (MDUse),
    .HI    (HI),
    .LO    (LO),
    .Busy  (Busy),
    .Stall (Stall)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one long op at a falling edge, check Stall in the Start cycle,
  // then check Busy in each of the n busy cycles (HI/LO still old in the
  // last one) and the drop cycle, where Stall must also be low.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned n, input logic use_d);
    logic [63:0] old_hl;
    old_hl = {HI, LO};
    Start = 1'b1; Op = op; A = a; B = b; MDUse = use_d;
    #1;
    check({tag, " stall@start"}, 64'(Stall), 64'(use_d));
    check({tag, " busy@start"}, 64'(Busy), 64'd0);
    for (int unsigned i = 1; i <= n; i++) begin
      @(negedge Clk);
      Start = 1'b0; Op = 3'd0;
      #1;
      check($sformatf("%s busy c%0d", tag, i), 64'(Busy), 64'd1);
      if (i == n) begin
        check({tag, " stall last busy"}, 64'(Stall), 64'(use_d));
        check({tag, " hl held"}, {HI, LO}, old_hl);
      end
    end
    @(negedge Clk);
    #1;
    check({tag, " busy drop"}, 64'(Busy), 64'd0);
    check({tag, " stall drop"}, 64'(Stall), 64'd0);
    MDUse = 1'b0;
  endtask

  // Single-cycle op (MTHI/MTLO/NOP) issued at a falling edge.
  task automatic one_shot(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; Op = op; A = a; B = '0;
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
    #1;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0; MDUse = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("reset HI", 64'(HI), 64'd0);
    check("reset LO", 64'(LO), 64'd0);
    check("reset Busy", 64'(Busy), 64'd0);
    check("reset Stall", 64'(Stall), 64'd0);
    @(negedge Clk);

    // MULT -1 * 2 with a dependent MFLO in D
    run_op("MULT", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b1);
    check("MULT HI", 64'(HI), 64'hFFFF_FFFF);
    check("MULT LO", 64'(LO), 64'hFFFF_FFFE);

    run_op("MULTU", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
    check("MULTU HI", 64'(HI), 64'h0000_0001);
    check("MULTU LO", 64'(LO), 64'hFFFF_FFFE);

    // Busy with MDUse low must not stall
    Start = 1'b1; Op = 3'd1; A = 32'd3; B = 32'd4; MDUse = 1'b0;
    @(negedge Clk);
    Start = 1'b0; Op = '0; #1;
    check("stall needs MDUse", 64'(Stall), 64'd0);
    repeat (5) @(negedge Clk);
    #1;
    check("MULT 3*4", {HI, LO}, 64'd12);

    run_op("DIV", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b1);
    check("DIV LO", 64'(LO), 64'hFFFF_FFFD);
    check("DIV HI", 64'(HI), 64'hFFFF_FFFF);

    run_op("DIVU", 3'd4, 32'd7, 32'd2, 10, 1'b0);
    check("DIVU LO", 64'(LO), 64'd3);
    check("DIVU HI", 64'(HI), 64'd1);

    run_op("DIVOVF", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
    check("DIVOVF LO", 64'(LO), 64'h8000_0000);
    check("DIVOVF HI", 64'(HI), 64'd0);

    run_op("DIV0", 3'd3, 32'd55, 32'd0, 10, 1'b0);
    check("DIV0 LO kept", 64'(LO), 64'h8000_0000);
    check("DIV0 HI kept", 64'(HI), 64'd0);

    one_shot(3'd5, 32'h1234_5678);
    check("MTHI HI", 64'(HI), 64'h1234_5678);
    check("MTHI Busy", 64'(Busy), 64'd0);
    check("MTHI LO kept", 64'(LO), 64'h8000_0000);
    one_shot(3'd6, 32'hCAFE_F00D);
    check("MTLO LO", 64'(LO), 64'hCAFE_F00D);
    check("MTLO HI kept", 64'(HI), 64'h1234_5678);

    one_shot(3'd0, 32'hDEAD_BEEF);
    check("NOP HI", 64'(HI), 64'h1234_5678);
    check("NOP LO", 64'(LO), 64'hCAFE_F00D);
    check("NOP Busy", 64'(Busy), 64'd0);

    // Accumulate base HI=0, LO=0xFFFFFFFF, A=B=1
    one_shot(3'd5, 32'd0);
    one_shot(3'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("MADD", 3'd7, 32'd1, 32'd1, 5, 1'b1);
    check("MADD HI", 64'(HI), 64'd1);
    check("MADD LO", 64'(LO), 64'd0);
`else
    Start = 1'b1; Op = 3'd7; A = 32'd1; B = 32'd1; MDUse = 1'b1;
    #1;
    check("op7 no stall", 64'(Stall), 64'd0);
    @(negedge Clk);
    Start = 1'b0; Op = '0; MDUse = 1'b0; #1;
    check("op7 no busy", 64'(Busy), 64'd0);
    repeat (5) @(negedge Clk);
    #1;
    check("op7 HI kept", 64'(HI), 64'd0);
    check("op7 LO kept", 64'(LO), 64'hFFFF_FFFF);
`endif

    // Reset held two cycles in the middle of a DIV aborts it
    one_shot(3'd5, 32'hAAAA_5555);
    Start = 1'b1; Op = 3'd4; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0; Op = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst mid HI", 64'(HI), 64'd0);
    check("rst mid LO", 64'(LO), 64'd0);
    check("rst mid Busy", 64'(Busy), 64'd0);
    repeat (12) @(negedge Clk);
    #1;
    check("rst no late update", {HI, LO}, 64'd0);
    check("rst stays idle", 64'(Busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
